countdown_timer_mux: RTL and testbench

- Next-generation hh:mm:ss countdown timer with keypad entry. Parametrised in clock rate, display scan rate and alarm length.
- Adds pause/resume, clear, entry validation, a done pulse, a timed alarm and a blinking display on expiry.
- Drives the board's 8-digit multiplexed 7-segment display directly. The one-hot keypad and mode/strobe inputs come from the board I/O top.

---
 rtl/countdown_timer_mux_pkg.sv | 74 +++++++
 rtl/countdown_timer_mux_if.sv | 32 +++
 rtl/countdown_timer_mux_bcd_seg_lut.sv | 23 ++
 rtl/countdown_timer_mux.sv | 235 +++++++++++++++++++++++
 tb/tb_countdown_timer_mux.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_mux_pkg.sv
// Shared definitions for the hh:mm:ss countdown timer.
// Holds the controller state encoding, the per-slot digit-enable patterns,
// the BCD digit limits and small helpers for entry clamping and the
// one-second BCD decrement. Digit position 0 is h_ten, 5 is s_one.
package countdown_timer_mux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

  // Six BCD digits, element 0 = h_ten ... element 5 = s_one.
  typedef logic [5:0][3:0] digits_t;

  localparam logic [3:0] BCD_MAX_ONE = 4'd9;
  localparam logic [3:0] BCD_MAX_TEN = 4'd5;

  // Active-low digit enables per scan slot; digits 6-7 stay dark.
  localparam logic [7:0] COM_SLOT0 = 8'b0111_1111;
  localparam logic [7:0] COM_SLOT1 = 8'b1011_1111;
  localparam logic [7:0] COM_SLOT2 = 8'b1101_1111;
  localparam logic [7:0] COM_SLOT3 = 8'b1110_1111;
  localparam logic [7:0] COM_SLOT4 = 8'b1111_0111;
  localparam logic [7:0] COM_SLOT5 = 8'b1111_1011;
  localparam logic [7:0] COM_OFF   = 8'hFF;

  function automatic logic [7:0] com_pattern(input logic [2:0] slot);
    case (slot)
      3'd0:    return COM_SLOT0;
      3'd1:    return COM_SLOT1;
      3'd2:    return COM_SLOT2;
      3'd3:    return COM_SLOT3;
      3'd4:    return COM_SLOT4;
      3'd5:    return COM_SLOT5;
      default: return COM_OFF;
    endcase
  endfunction

  // Tens of minutes and tens of seconds top out at 5; everything else at 9.
  function automatic logic [3:0] digit_limit(input int unsigned pos);
    return (pos == 2 || pos == 4) ? BCD_MAX_TEN : BCD_MAX_ONE;
  endfunction

  function automatic logic [3:0] clamp_digit(input int unsigned pos, input logic [3:0] v);
    logic [3:0] lim;
    lim = digit_limit(pos);
    return (v > lim) ? lim : v;
  endfunction

  // Subtract one second, rippling the borrow from s_one up towards h_ten.
  function automatic digits_t bcd_dec(input digits_t d);
    digits_t     r;
    logic        borrow;
    int unsigned pos;
    r      = d;
    borrow = 1'b1;
    for (int unsigned j = 0; j < 6; j++) begin
      pos = 5 - j;
      if (borrow) begin
        if (r[pos] == 4'd0) begin
          r[pos] = digit_limit(pos);
        end else begin
          r[pos] = r[pos] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_timer_mux_if.sv
// Board-side signal bundle of the countdown timer.
//   set_mode     entry-mode switch level
//   start_pause  start / pause / resume / acknowledge strobe
//   clear        zero-time strobe
//   keypad       one-hot digit keys (bit n = digit n)
//   seg_data     {a,b,c,d,e,f,g,dp}, active-high
//   seg_com      digit enables, active-low
//   running      high while counting
//   done         one-cycle expiry pulse
//   alarm        timed alarm after expiry
// master drives the controls (board I/O side), slave is the timer.
interface countdown_timer_mux_if;
  logic       set_mode;
  logic       start_pause;
  logic       clear;
  logic [9:0] keypad;
  logic [7:0] seg_data;
  logic [7:0] seg_com;
  logic       running;
  logic       done;
  logic       alarm;

  modport master (
    output set_mode, start_pause, clear, keypad,
    input  seg_data, seg_com, running, done, alarm
  );

  modport slave (
    input  set_mode, start_pause, clear, keypad,
    output seg_data, seg_com, running, done, alarm
  );
endinterface

// File: rtl/countdown_timer_mux_bcd_seg_lut.sv
// Combinational BCD to 7-segment lookup.
//   digit  in  4  BCD value
//   seg    out 7  {a,b,c,d,e,f,g}, active-high; blank for values above 9
module bcd_seg_lut (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    case (digit)
      4'd0:    seg = 7'b111_1110;
      4'd1:    seg = 7'b011_0000;
      4'd2:    seg = 7'b110_1101;
      4'd3:    seg = 7'b111_1001;
      4'd4:    seg = 7'b011_0011;
      4'd5:    seg = 7'b101_1011;
      4'd6:    seg = 7'b101_1111;
      4'd7:    seg = 7'b111_0000;
      4'd8:    seg = 7'b111_1111;
      4'd9:    seg = 7'b111_1011;
      default: seg = '0;
    endcase
  end
endmodule

// File: rtl/countdown_timer_mux.sv
// hh:mm:ss countdown timer with keypad entry and a multiplexed 8-digit
// 7-segment display (six digits used).
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   bus   slave side of countdown_timer_mux_if (controls, display, status)
// Parameters: CLK_HZ clocks per second, SCAN_DIV clocks per display slot,
// ALARM_SEC alarm duration in seconds after expiry.
module countdown_timer_mux
  import countdown_timer_mux_pkg::*;
#(
  parameter int CLK_HZ    = 1000,
  parameter int SCAN_DIV  = 1,
  parameter int ALARM_SEC = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  countdown_timer_mux_if.slave  bus
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int ACNT_W  = $clog2(ALARM_SEC * CLK_HZ + 1);

  localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(CLK_HZ - 1);
  localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(CLK_HZ / 2);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [ACNT_W-1:0]  ALARM_CYC  = ACNT_W'(ALARM_SEC * CLK_HZ);

  state_e               state_q, state_d;
  digits_t              dig_q, dig_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [ACNT_W-1:0]    acnt_q, acnt_d;
  logic                 alarm_q, alarm_d;
  logic                 done_q, done_d;
  logic                 running_q, running_d;
  logic [9:0]           kp_prev_q, kp_prev_d;
  logic [SCAN_W-1:0]    scan_q, scan_d;
  logic [2:0]           slot_q, slot_d;
  logic [7:0]           seg_com_q, seg_com_d;
  logic [7:0]           seg_data_q, seg_data_d;

  digits_t              dig_dec;
  logic                 dec_zero;
  logic                 key_press;
  logic [3:0]           key_val;
  logic [PRESC_W-1:0]   presc_next;
  logic                 presc_wrap;
  logic [3:0]           mux_digit;
  logic [6:0]           lut_seg;
  logic                 dp_on;

  assign dig_dec    = bcd_dec(dig_q);
  assign dec_zero   = (dig_dec == '0);
  assign presc_wrap = (presc_q == PRESC_MAX);
  assign presc_next = presc_wrap ? '0 : presc_q + 1'b1;

  // A press is a clean single key arriving from an all-released keypad.
  assign key_press = $onehot(bus.keypad) && (kp_prev_q == '0);

  always_comb begin
    key_val = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (bus.keypad[i]) key_val = 4'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    ptr_d     = ptr_q;
    presc_d   = presc_q;
    acnt_d    = acnt_q;
    alarm_d   = alarm_q;
    done_d    = 1'b0;
    kp_prev_d = bus.keypad;

    if (bus.set_mode) begin
      presc_d = '0;
      acnt_d  = '0;
      alarm_d = 1'b0;
      if (state_q != ST_SET) begin
        state_d = ST_SET;
        ptr_d   = '0;
      end else if (bus.clear) begin
        dig_d = '0;
        ptr_d = '0;
      end else if (key_press) begin
        for (int unsigned i = 0; i < 6; i++) begin
          if (ptr_q == 3'(i)) dig_d[i] = clamp_digit(i, key_val);
        end
        ptr_d = (ptr_q == 3'd5) ? 3'd0 : ptr_q + 3'd1;
      end
    end else begin
      case (state_q)
        ST_SET: begin
          // set_mode released: leave entry with the digits kept.
          state_d = ST_IDLE;
        end
        ST_IDLE: begin
          ptr_d   = '0;
          presc_d = '0;
          if (bus.clear) begin
            dig_d = '0;
          end else if (bus.start_pause && (dig_q != '0)) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.clear) begin
            dig_d   = '0;
            presc_d = '0;
            state_d = ST_IDLE;
          end else begin
            presc_d = presc_next;
            if (presc_wrap) begin
              dig_d = dig_dec;
            end
            // Expiry wins over a coincident pause request.
            if (presc_wrap && dec_zero) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              alarm_d = 1'b1;
              acnt_d  = ALARM_CYC;
            end else if (bus.start_pause) begin
              state_d = ST_PAUSE;
            end
          end
        end
        ST_PAUSE: begin
          if (bus.clear) begin
            dig_d   = '0;
            presc_d = '0;
            state_d = ST_IDLE;
          end else if (bus.start_pause) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (bus.clear) begin
            dig_d   = '0;
            presc_d = '0;
            acnt_d  = '0;
            alarm_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            presc_d = presc_next;
            if (acnt_q != '0) begin
              acnt_d = acnt_q - 1'b1;
              if (acnt_q == ACNT_W'(1)) alarm_d = 1'b0;
            end
            if (bus.start_pause) begin
              acnt_d  = '0;
              alarm_d = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  always_comb begin
    scan_d = scan_q + 1'b1;
    slot_d = slot_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      slot_d = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
    end
  end

  always_comb begin
    mux_digit = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (slot_q == 3'(i)) mux_digit = dig_q[i];
    end
  end

  bcd_seg_lut u_lut (
    .digit (mux_digit),
    .seg   (lut_seg)
  );

  // Separators after h_one and m_one; in SET the entry position is marked too.
  assign dp_on = (slot_q == 3'd1) || (slot_q == 3'd3) ||
                 ((state_q == ST_SET) && (ptr_q == slot_q));

  always_comb begin
    seg_com_d  = com_pattern(slot_q);
    seg_data_d = {lut_seg, dp_on};
    if ((state_q == ST_DONE) && (presc_q >= PRESC_HALF)) seg_data_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      dig_q      <= '0;
      ptr_q      <= '0;
      presc_q    <= '0;
      acnt_q     <= '0;
      alarm_q    <= 1'b0;
      done_q     <= 1'b0;
      running_q  <= 1'b0;
      kp_prev_q  <= '0;
      scan_q     <= '0;
      slot_q     <= '0;
      seg_com_q  <= COM_OFF;
      seg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      dig_q      <= dig_d;
      ptr_q      <= ptr_d;
      presc_q    <= presc_d;
      acnt_q     <= acnt_d;
      alarm_q    <= alarm_d;
      done_q     <= done_d;
      running_q  <= running_d;
      kp_prev_q  <= kp_prev_d;
      scan_q     <= scan_d;
      slot_q     <= slot_d;
      seg_com_q  <= seg_com_d;
      seg_data_q <= seg_data_d;
    end
  end

  assign bus.seg_com  = seg_com_q;
  assign bus.seg_data = seg_data_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.alarm    = alarm_q;

endmodule

// File: tb/tb_countdown_timer_mux.sv
// Directed bench for countdown_timer_mux (CLK_HZ=10, SCAN_DIV=1, ALARM_SEC=2).
// The displayed time is recovered by decoding six consecutive scan slots.
module tb_countdown_timer_mux;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  countdown_timer_mux_if bus_if ();

  countdown_timer_mux #(
    .CLK_HZ    (10),
    .SCAN_DIV  (1),
    .ALARM_SEC (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b111_1110;
      1: return 7'b011_0000;
      2: return 7'b110_1101;
      3: return 7'b111_1001;
      4: return 7'b011_0011;
      5: return 7'b101_1011;
      6: return 7'b101_1111;
      7: return 7'b111_0000;
      8: return 7'b111_1111;
      9: return 7'b111_1011;
      default: return 7'b000_0000;
    endcase
  endfunction

  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    logic [3:0] r;
    r = 4'hF;
    for (int d = 0; d < 10; d++) if (seg_ref(d) == s) r = 4'(d);
    return r;
  endfunction

  function automatic int slot_of(input logic [7:0] com);
    case (com)
      8'b0111_1111: return 0;
      8'b1011_1111: return 1;
      8'b1101_1111: return 2;
      8'b1110_1111: return 3;
      8'b1111_0111: return 4;
      8'b1111_1011: return 5;
      default:      return 7;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus_if.start_pause = 1'b1;
    @(negedge clk);
    bus_if.start_pause = 1'b0;
  endtask

  task automatic pulse_clear();
    bus_if.clear = 1'b1;
    @(negedge clk);
    bus_if.clear = 1'b0;
  endtask

  task automatic press(input int d);
    bus_if.keypad = 10'b1 << d;
    @(negedge clk);
    bus_if.keypad = '0;
    @(negedge clk);
  endtask

  // Time as hh:mm:ss hex nibbles (h_ten highest), dp[slot] per digit.
  task automatic read_time(output logic [23:0] t, output logic [5:0] dp);
    int s;
    t  = 24'hFFFFFF;
    dp = '0;
    repeat (6) begin
      @(negedge clk);
      s = slot_of(bus_if.seg_com);
      if (s < 6) begin
        t[(5 - s) * 4 +: 4] = seg_decode(bus_if.seg_data[7:1]);
        dp[s] = bus_if.seg_data[0];
      end
    end
  endtask

  task automatic load_time(input logic [23:0] t);
    logic [23:0] v;
    v = t;
    bus_if.set_mode = 1'b1;
    tick(1);
    for (int i = 0; i < 6; i++) press(int'(v[(5 - i) * 4 +: 4]));
    bus_if.set_mode = 1'b0;
    tick(1);
  endtask

  task automatic wait_done(input int bound, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (bus_if.done) seen = 1'b1;
    end
    if (!seen) cyc = -1;
  endtask

  task automatic reset_release_check(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check(tag, bus_if.seg_com, 8'b0111_1111);
  endtask

  initial begin
    logic [23:0] t;
    logic [5:0]  dp;
    int          cyc;
    int          done_cnt;
    int          done_at;
    int          alarm_hi;

    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus_if.set_mode    = 1'b0;
    bus_if.start_pause = 1'b0;
    bus_if.clear       = 1'b0;
    bus_if.keypad      = '0;

    tick(3);
    check("rst_seg_com",  bus_if.seg_com, 8'hFF);
    check("rst_seg_data", bus_if.seg_data, 8'h00);
    check("rst_status",   {bus_if.running, bus_if.done, bus_if.alarm}, 3'b000);
    reset_release_check("scan_slot0");
    @(negedge clk);
    check("scan_slot1", bus_if.seg_com, 8'b1011_1111);

    // Entry then countdown.
    load_time(24'h000105);
    pulse_start();
    check("run_running", bus_if.running, 1'b1);
    tick(10);
    read_time(t, dp);
    check("run_10cyc", t, 24'h000104);
    check("run_dp", dp, 6'b001010);
    tick(44);
    read_time(t, dp);
    check("run_60cyc", t, 24'h000059);
    pulse_clear();
    check("clr1_running", bus_if.running, 1'b0);

    // Expiry, done pulse, alarm and blink.
    load_time(24'h000002);
    pulse_start();
    done_cnt = 0;
    done_at  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus_if.done) begin
        done_cnt++;
        done_at = k;
      end
    end
    check("done_count", done_cnt, 1);
    check("done_cycle", done_at, 20);
    check("done_alarm", bus_if.alarm, 1'b1);
    check("done_not_running", bus_if.running, 1'b0);
    alarm_hi = 1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (bus_if.alarm) alarm_hi++;
      if (k == 1) check("done_one_cycle", bus_if.done, 1'b0);
      if (k == 19) check("alarm_k19", bus_if.alarm, 1'b1);
      if (k == 20) check("alarm_k20", bus_if.alarm, 1'b0);
      if (k <= 15) check($sformatf("blink_k%0d", k), bus_if.seg_data == 8'h00,
                         (k >= 6 && k <= 10) ? 1'b1 : 1'b0);
    end
    check("alarm_len", alarm_hi, 20);
    pulse_start();
    tick(1);
    check("ack_alarm", bus_if.alarm, 1'b0);
    check("ack_running", bus_if.running, 1'b0);

    // Entry clamping, multi-key rejection, pointer wrap, clear in SET.
    bus_if.set_mode = 1'b1;
    tick(1);
    press(1);
    press(2);
    press(7);
    bus_if.keypad = 10'b00_0000_0110;
    tick(1);
    bus_if.keypad = 10'b01_0000_0000;
    tick(1);
    bus_if.keypad = '0;
    tick(1);
    press(4);
    read_time(t, dp);
    check("set_clamp_mten", t, 24'h125400);
    check("set_ptr4_dp", dp, 6'b011010);
    press(9);
    press(3);
    read_time(t, dp);
    check("set_clamp_sten", t, 24'h125453);
    check("set_wrap_dp", dp, 6'b001011);
    press(8);
    read_time(t, dp);
    check("set_overwrite", t, 24'h825453);
    check("set_ptr1_dp", dp, 6'b001010);
    pulse_clear();
    read_time(t, dp);
    check("set_clear", t, 24'h000000);
    check("set_clear_dp", dp, 6'b001011);
    bus_if.set_mode = 1'b0;
    tick(1);

    // Pause holds time and prescaler; expiry lands 97 cycles after resume.
    load_time(24'h000010);
    pulse_start();
    tick(2);
    pulse_start();
    check("pause_running", bus_if.running, 1'b0);
    tick(50);
    read_time(t, dp);
    check("pause_hold", t, 24'h000010);
    pulse_start();
    check("resume_running", bus_if.running, 1'b1);
    wait_done(200, cyc);
    check("resume_done_cycle", cyc, 97);
    pulse_start();

    // Hour borrow, clear mid-run, start from zero ignored.
    load_time(24'h010000);
    pulse_start();
    tick(10);
    read_time(t, dp);
    check("hour_borrow", t, 24'h005959);
    pulse_clear();
    check("clr_running", bus_if.running, 1'b0);
    read_time(t, dp);
    check("clr_time", t, 24'h000000);
    pulse_start();
    check("zero_start", bus_if.running, 1'b0);
    tick(2);
    check("zero_start_hold", bus_if.running, 1'b0);

    // Asynchronous reset mid-run.
    load_time(24'h000005);
    pulse_start();
    tick(3);
    #2 rst = 1'b0;
    #1;
    check("arst_run_com",  bus_if.seg_com, 8'hFF);
    check("arst_run_data", bus_if.seg_data, 8'h00);
    check("arst_run_status", {bus_if.running, bus_if.done, bus_if.alarm}, 3'b000);
    reset_release_check("arst_run_slot0");
    read_time(t, dp);
    check("arst_run_time", t, 24'h000000);

    // Asynchronous reset in DONE with alarm raised.
    load_time(24'h000001);
    pulse_start();
    wait_done(50, cyc);
    check("arst_done_cycle", cyc, 10);
    check("arst_done_alarm_pre", bus_if.alarm, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_done_status", {bus_if.running, bus_if.done, bus_if.alarm}, 3'b000);
    check("arst_done_com", bus_if.seg_com, 8'hFF);
    reset_release_check("arst_done_slot0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
